// File: rtl/out_uart_tx_if.sv
// Byte-stream interface between the CPU output path and the UART transmitter.
// The master drives strobe/data; the slave reports line and queue status.
interface out_uart_tx_if #(
  parameter int DEPTH = 4
);
  logic                    out_strobe;
  logic [7:0]              out_data;
  logic                    txd;
  logic                    busy;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    overflow;

  modport master (
    output out_strobe, out_data,
    input  txd, busy, fifo_count, overflow
  );

  modport slave (
    input  out_strobe, out_data,
    output txd, busy, fifo_count, overflow
  );
endinterface

// File: rtl/out_uart_tx.sv
// 8N1 LSB-first UART transmitter fed by a small drop-on-full FIFO.
// Bytes arriving while the FIFO is full are discarded and flagged in a sticky overflow bit.
module out_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int DEPTH        = 4
) (
  input  logic         clk,
  input  logic         reset,
  out_uart_tx_if.slave bus
);
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int CCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CCW-1:0]  r_cyc;
  logic [2:0]      r_bit;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic [7:0]      r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_nxt;
  logic            r_txd;
  logic            r_busy;
  logic            r_ovf;
  logic            w_txd_nxt;
  logic            w_busy_nxt;
  logic            w_cyc_last;
  logic            w_has;
  logic            w_pop;
  logic            w_push;

  assign w_cyc_last = (r_cyc == CCW'(CLKS_PER_BIT - 1));
  assign w_has      = (r_count != CW'(0));
  // Pops use the pre-edge count, so a byte written this edge waits one cycle.
  assign w_pop      = w_has && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_cyc_last));
  assign w_push     = bus.out_strobe && ((r_count < CW'(DEPTH)) || w_pop);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = w_has ? S_START : S_IDLE;
      S_START: w_state_nxt = w_cyc_last ? S_DATA : S_START;
      S_DATA:  w_state_nxt = (w_cyc_last && (r_bit == 3'd7)) ? S_STOP : S_DATA;
      S_STOP: begin
        if (w_cyc_last) begin
          w_state_nxt = w_has ? S_START : S_IDLE;
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values; txd is registered from the next state
  always_comb begin
    w_shift_nxt = r_shift;
    if (w_pop) begin
      w_shift_nxt = r_mem[r_rptr];
    end else if ((r_state == S_DATA) && w_cyc_last) begin
      w_shift_nxt = {1'b0, r_shift[7:1]};
    end else begin
      w_shift_nxt = r_shift;
    end

    case (w_state_nxt)
      S_START: w_txd_nxt = 1'b0;
      S_DATA:  w_txd_nxt = w_shift_nxt[0];
      default: w_txd_nxt = 1'b1;
    endcase

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE) || (w_count_nxt != CW'(0));
  end

  // Counters, shifter, FIFO storage and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc   <= CCW'(0);
      r_bit   <= 3'd0;
      r_shift <= 8'd0;
      r_wptr  <= PW'(0);
      r_rptr  <= PW'(0);
      r_count <= CW'(0);
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'd0;
      end
    end else begin
      r_cyc   <= ((r_state == S_IDLE) || w_cyc_last) ? CCW'(0) : r_cyc + CCW'(1);
      if (r_state == S_START) begin
        r_bit <= 3'd0;
      end else if ((r_state == S_DATA) && w_cyc_last) begin
        r_bit <= r_bit + 3'd1;
      end else begin
        r_bit <= r_bit;
      end
      r_shift <= w_shift_nxt;
      if (w_push) begin
        r_mem[r_wptr] <= bus.out_data;
        r_wptr        <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_count <= w_count_nxt;
      r_txd   <= w_txd_nxt;
      r_busy  <= w_busy_nxt;
      r_ovf   <= r_ovf | (bus.out_strobe & ~w_push);
    end
  end

  assign bus.txd        = r_txd;
  assign bus.busy       = r_busy;
  assign bus.fifo_count = r_count;
  assign bus.overflow   = r_ovf;
endmodule
